// File: rtl/uart_receiver_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_receiver_if : serial line input and receive-status bundle | Rev 1.0
// ---------------------------------------------------------------------------
interface uart_receiver_if;
  logic       din;
  logic [7:0] data_rx;
  logic       valid;
  logic       frame_err;
  logic       busy;
  logic [2:0] state;

  modport master (
    output din,
    input  data_rx, valid, frame_err, busy, state
  );

  modport slave (
    input  din,
    output data_rx, valid, frame_err, busy, state
  );
endinterface
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_receiver : 8N1 serial receiver, mid-bit sampling, framing-error flag
// Rev 1.0
// ---------------------------------------------------------------------------
module uart_receiver #(
  parameter int CLKS_PER_BIT = 279
) (
  input  logic           clk,
  input  logic           rst,
  uart_receiver_if.slave rx
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = ($clog2(CLKS_PER_BIT) > 9) ? $clog2(CLKS_PER_BIT) : 9;
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_e;

  logic             sync1_q;
  logic             din_s_q;
  state_e           state_q,   state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic [2:0]       index_q,   index_d;
  logic [7:0]       shift_q,   shift_d;
  logic [7:0]       data_q,    data_d;
  logic             valid_q,   valid_d;
  logic             ferr_q,    ferr_d;

  // Both synchronizer stages reset high so reset release never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      din_s_q <= 1'b1;
    end else begin
      sync1_q <= rx.din;
      din_s_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      counter_q <= '0;
      index_q   <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      index_q   <= index_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    index_d   = index_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      IDLE: begin
        counter_d = '0;
        index_d   = '0;
        if (!din_s_q) state_d = START;
      end

      START: begin
        counter_d = counter_q + CNT_ONE;
        if (counter_q == HALF_M1) begin
          counter_d = '0;
          index_d   = '0;
          state_d   = din_s_q ? IDLE : DATA;
        end
      end

      // Counting a full bit from the start-bit midpoint lands on each data midpoint.
      DATA: begin
        counter_d = counter_q + CNT_ONE;
        if (counter_q == BIT_M1) begin
          counter_d        = '0;
          shift_d[index_q] = din_s_q;
          if (index_q == 3'd7) state_d = STOP;
          else                 index_d = index_q + 3'd1;
        end
      end

      STOP: begin
        counter_d = counter_q + CNT_ONE;
        if (counter_q == BIT_M1) begin
          counter_d = '0;
          if (din_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end

      WAIT_IDLE: begin
        if (din_s_q) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign rx.data_rx   = data_q;
  assign rx.valid     = valid_q;
  assign rx.frame_err = ferr_q;
  assign rx.busy      = (state_q != IDLE);
  assign rx.state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_receiver : directed checks at the default and minimum bit period
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_uart_receiver;

  localparam int CPB_A = 279;
  localparam int CPB_B = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  uart_receiver_if ifa ();
  uart_receiver_if ifb ();

  uart_receiver #(.CLKS_PER_BIT(CPB_A)) dut_a (.clk(clk), .rst(rst), .rx(ifa));
  uart_receiver #(.CLKS_PER_BIT(CPB_B)) dut_b (.clk(clk), .rst(rst), .rx(ifb));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: records every valid / frame_err cycle with the edge count.
  int         va_cnt = 0, fa_cnt = 0, vb_cnt = 0, fb_cnt = 0, both_cnt = 0;
  int         va_cyc [16];
  logic [7:0] va_dat [16];
  int         fa_cyc = 0, vb_cyc = 0;
  logic [7:0] vb_dat = 8'h00;

  always @(negedge clk) begin
    if (ifa.valid) begin
      if (va_cnt < 16) begin
        va_cyc[va_cnt] <= cyc;
        va_dat[va_cnt] <= ifa.data_rx;
      end
      va_cnt <= va_cnt + 1;
    end
    if (ifa.frame_err) begin
      fa_cyc <= cyc;
      fa_cnt <= fa_cnt + 1;
    end
    if (ifb.valid) begin
      vb_cyc <= cyc;
      vb_dat <= ifb.data_rx;
      vb_cnt <= vb_cnt + 1;
    end
    if (ifb.frame_err) fb_cnt <= fb_cnt + 1;
    if ((ifa.valid && ifa.frame_err) || (ifb.valid && ifb.frame_err)) both_cnt <= both_cnt + 1;
  end

  task automatic wait_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg(input int target);
    wait_to(target);
    @(negedge clk);
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) ifb.din = v;
    else     ifa.din = v;
  endtask

  // Called aligned just after a rising edge; e0 is the first edge that samples the start bit.
  task automatic send_frame(input bit sel, input logic [7:0] b, input logic stopb,
                            input int cpb, input int stop_len, output int e0);
    drive(sel, 1'b0);
    e0 = cyc + 1;
    hold(cpb);
    for (int i = 0; i < 8; i++) begin
      drive(sel, b[i]);
      hold(cpb);
    end
    drive(sel, stopb);
    hold(stop_len);
    drive(sel, 1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    ifa.din = 1'b1;
    ifb.din = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (ifa.data_rx !== 8'h00) begin n_fail++; $display("FAIL por_data_rx: got %h want 00", ifa.data_rx); end
    n_cmp++; if (ifa.valid !== 1'b0) begin n_fail++; $display("FAIL por_valid: got %b want 0", ifa.valid); end
    n_cmp++; if (ifa.frame_err !== 1'b0) begin n_fail++; $display("FAIL por_frame_err: got %b want 0", ifa.frame_err); end
    n_cmp++; if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL por_busy: got %b want 0", ifa.busy); end
    n_cmp++; if (ifa.state !== 3'd0) begin n_fail++; $display("FAIL por_state: got %0d want 0", ifa.state); end
    n_cmp++; if (ifb.state !== 3'd0) begin n_fail++; $display("FAIL por_state_b: got %0d want 0", ifb.state); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    hold(5);
    n_cmp++; if (ifa.state !== 3'd0) begin n_fail++; $display("FAIL por_idle_after_release: got %0d want 0", ifa.state); end
  endtask

  task automatic test_single_byte;
    int e0;
    int v0;
    int f0;
    v0 = va_cnt;
    f0 = fa_cnt;
    send_frame(1'b0, 8'hA5, 1'b1, CPB_A, CPB_A, e0);
    hold(5);
    n_cmp++; if (va_cnt - v0 !== 1) begin n_fail++; $display("FAIL single_valid_count: got %0d want 1", va_cnt - v0); end
    n_cmp++; if (va_cyc[v0] !== e0 + 2652) begin n_fail++; $display("FAIL single_valid_time: got E0+%0d want E0+2652", va_cyc[v0] - e0); end
    n_cmp++; if (va_dat[v0] !== 8'hA5) begin n_fail++; $display("FAIL single_strobe_data: got %h want a5", va_dat[v0]); end
    n_cmp++; if (ifa.data_rx !== 8'hA5) begin n_fail++; $display("FAIL single_data_hold: got %h want a5", ifa.data_rx); end
    n_cmp++; if (fa_cnt !== f0) begin n_fail++; $display("FAIL single_no_frame_err: got %0d want %0d", fa_cnt, f0); end
  endtask

  task automatic test_glitch;
    int e0;
    int v0;
    int f0;
    v0 = va_cnt;
    f0 = fa_cnt;
    drive(1'b0, 1'b0);
    e0 = cyc + 1;
    at_neg(e0 + 2);
    n_cmp++; if (ifa.state !== 3'd1) begin n_fail++; $display("FAIL glitch_start_entry: got %0d want 1", ifa.state); end
    n_cmp++; if (ifa.busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy: got %b want 1", ifa.busy); end
    wait_to(e0 + 49);
    drive(1'b0, 1'b1);
    at_neg(e0 + 140);
    n_cmp++; if (ifa.state !== 3'd1) begin n_fail++; $display("FAIL glitch_still_start: got %0d want 1", ifa.state); end
    at_neg(e0 + 141);
    n_cmp++; if (ifa.state !== 3'd0) begin n_fail++; $display("FAIL glitch_back_idle: got %0d want 0", ifa.state); end
    @(posedge clk);
    #1;
    hold(3000);
    n_cmp++; if (va_cnt !== v0) begin n_fail++; $display("FAIL glitch_no_valid: got %0d want %0d", va_cnt, v0); end
    n_cmp++; if (fa_cnt !== f0) begin n_fail++; $display("FAIL glitch_no_frame_err: got %0d want %0d", fa_cnt, f0); end
    n_cmp++; if (ifa.data_rx !== 8'hA5) begin n_fail++; $display("FAIL glitch_data_kept: got %h want a5", ifa.data_rx); end
  endtask

  task automatic test_frame_err;
    int e0;
    int v0;
    int f0;
    int n;
    v0 = va_cnt;
    f0 = fa_cnt;
    send_frame(1'b0, 8'h3C, 1'b0, CPB_A, 2000, e0);
    // send_frame raised the line at its end; pull it low again to extend the break.
    drive(1'b0, 1'b0);
    n_cmp++; if (fa_cnt - f0 !== 1) begin n_fail++; $display("FAIL ferr_count: got %0d want 1", fa_cnt - f0); end
    n_cmp++; if (fa_cyc !== e0 + 2652) begin n_fail++; $display("FAIL ferr_time: got E0+%0d want E0+2652", fa_cyc - e0); end
    n_cmp++; if (va_cnt !== v0) begin n_fail++; $display("FAIL ferr_no_valid: got %0d want %0d", va_cnt, v0); end
    n_cmp++; if (ifa.data_rx !== 8'hA5) begin n_fail++; $display("FAIL ferr_data_kept: got %h want a5", ifa.data_rx); end
    n_cmp++; if (ifa.state !== 3'd4) begin n_fail++; $display("FAIL ferr_wait_idle: got %0d want 4", ifa.state); end
    n = cyc;
    drive(1'b0, 1'b1);
    at_neg(n + 2);
    n_cmp++; if (ifa.state !== 3'd4) begin n_fail++; $display("FAIL ferr_hold_until_sync: got %0d want 4", ifa.state); end
    at_neg(n + 3);
    n_cmp++; if (ifa.state !== 3'd0) begin n_fail++; $display("FAIL ferr_release_idle: got %0d want 0", ifa.state); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    int v0;
    int f0;
    drive(1'b0, 1'b0);
    hold(800);
    @(negedge clk);
    n_cmp++; if (ifa.state !== 3'd2) begin n_fail++; $display("FAIL rstmid_in_data: got %0d want 2", ifa.state); end
    n_cmp++; if (ifa.busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b want 1", ifa.busy); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (ifa.data_rx !== 8'h00) begin n_fail++; $display("FAIL rstmid_data_rx: got %h want 00", ifa.data_rx); end
    n_cmp++; if (ifa.valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", ifa.valid); end
    n_cmp++; if (ifa.frame_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_frame_err: got %b want 0", ifa.frame_err); end
    n_cmp++; if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", ifa.busy); end
    n_cmp++; if (ifa.state !== 3'd0) begin n_fail++; $display("FAIL rstmid_state: got %0d want 0", ifa.state); end
    drive(1'b0, 1'b1);
    hold(5);
    rst = 1'b0;
    v0 = va_cnt;
    f0 = fa_cnt;
    hold(3000);
    n_cmp++; if (va_cnt !== v0) begin n_fail++; $display("FAIL rstmid_no_valid: got %0d want %0d", va_cnt, v0); end
    n_cmp++; if (fa_cnt !== f0) begin n_fail++; $display("FAIL rstmid_no_frame_err: got %0d want %0d", fa_cnt, f0); end
    n_cmp++; if (ifa.state !== 3'd0) begin n_fail++; $display("FAIL rstmid_idle_after: got %0d want 0", ifa.state); end
  endtask

  task automatic test_back_to_back;
    int         e [3];
    logic [7:0] bytes [3];
    int         v0;
    int         f0;
    bytes[0] = 8'h00;
    bytes[1] = 8'hFF;
    bytes[2] = 8'h55;
    v0 = va_cnt;
    f0 = fa_cnt;
    for (int k = 0; k < 3; k++) send_frame(1'b0, bytes[k], 1'b1, CPB_A, CPB_A, e[k]);
    hold(5);
    n_cmp++; if (va_cnt - v0 !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", va_cnt - v0); end
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (va_dat[v0 + k] !== bytes[k]) begin n_fail++; $display("FAIL b2b_data%0d: got %h want %h", k, va_dat[v0 + k], bytes[k]); end
      n_cmp++; if (va_cyc[v0 + k] !== e[k] + 2652) begin n_fail++; $display("FAIL b2b_time%0d: got E0+%0d want E0+2652", k, va_cyc[v0 + k] - e[k]); end
    end
    n_cmp++; if (va_cyc[v0 + 1] - va_cyc[v0] !== 2790) begin n_fail++; $display("FAIL b2b_spacing01: got %0d want 2790", va_cyc[v0 + 1] - va_cyc[v0]); end
    n_cmp++; if (va_cyc[v0 + 2] - va_cyc[v0 + 1] !== 2790) begin n_fail++; $display("FAIL b2b_spacing12: got %0d want 2790", va_cyc[v0 + 2] - va_cyc[v0 + 1]); end
    n_cmp++; if (ifa.data_rx !== 8'h55) begin n_fail++; $display("FAIL b2b_final_data: got %h want 55", ifa.data_rx); end
    n_cmp++; if (fa_cnt !== f0) begin n_fail++; $display("FAIL b2b_no_frame_err: got %0d want %0d", fa_cnt, f0); end
  endtask

  task automatic test_min_param;
    int e0;
    int v0;
    v0 = vb_cnt;
    send_frame(1'b1, 8'h81, 1'b1, CPB_B, CPB_B, e0);
    hold(10);
    n_cmp++; if (vb_cnt - v0 !== 1) begin n_fail++; $display("FAIL min_valid_count: got %0d want 1", vb_cnt - v0); end
    n_cmp++; if (vb_cyc !== e0 + 40) begin n_fail++; $display("FAIL min_valid_time: got E0+%0d want E0+40", vb_cyc - e0); end
    n_cmp++; if (vb_dat !== 8'h81) begin n_fail++; $display("FAIL min_strobe_data: got %h want 81", vb_dat); end
    n_cmp++; if (ifb.data_rx !== 8'h81) begin n_fail++; $display("FAIL min_data_hold: got %h want 81", ifb.data_rx); end
    n_cmp++; if (fb_cnt !== 0) begin n_fail++; $display("FAIL min_no_frame_err: got %0d want 0", fb_cnt); end
    n_cmp++; if (both_cnt !== 0) begin n_fail++; $display("FAIL strobe_exclusion: got %0d overlapping cycles want 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_back_to_back();
    test_min_param();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_receiver.md
# uart_receiver

Receive side of the UART link, directly downstream of the UART transmitter. Recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) from the serial line `din` at a fixed bit period of `CLKS_PER_BIT` clocks. Each byte is presented on `data_rx` with a one-cycle `valid` strobe. Framing errors are flagged separately. Default timing matches the transmitter's 279-clock bit period, so the two blocks loop back directly.

## Interface
- `CLKS_PER_BIT`, default 279: bit period in clk cycles; legal range ≥ 4. `HALF = CLKS_PER_BIT/2` (integer division; 139 at default).
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `din`  in  1  serial line, idle high, asynchronous to `clk`.
- `data_rx`  out  8  last correctly framed byte; holds until the next good frame.
- `valid`  out  1  one-cycle pulse when `data_rx` is updated.
- `frame_err`  out  1  one-cycle pulse when the stop bit samples 0.
- `busy`  out  1  high whenever state ≠ IDLE (decoded from the state register).
- `state`  out  3  current FSM state, for debugging.

## Operation
- **Synchronizer:** `din` passes through a 2-flop synchronizer, with both flops reset to 1. The FSM only ever sees the second flop, `din_s`.
- **Registers:** 9-bit `counter` (wide enough for `CLKS_PER_BIT` − 1), 3-bit `index`, 8-bit shift register.
- **State encoding:** IDLE=0, START=1, DATA=2, STOP=3, WAIT_IDLE=4.
- **IDLE**
  - Hold counter = 0 and index = 0.
  - If `din_s` = 0, go to START.
- **START**
  - Increment counter each clock.
  - At the edge where counter == HALF−1:
    - If `din_s` = 0, go to DATA with counter = 0 and index = 0.
    - Otherwise go to IDLE (glitch rejected; no flag is raised).
- **DATA**
  - Increment counter each clock.
  - At the edge where counter == CLKS_PER_BIT−1:
    - Write `din_s` into shift bit [index] and set counter = 0.
    - If index == 7, go to STOP; otherwise index = index + 1.
  - Net effect: each data bit is sampled at its midpoint.
- **STOP**
  - Increment counter each clock.
  - At the edge where counter == CLKS_PER_BIT−1:
    - If `din_s` = 1: load the shift register into `data_rx`, pulse `valid`, go to IDLE.
    - If `din_s` = 0: pulse `frame_err`, leave `data_rx` unchanged, go to WAIT_IDLE.
- **WAIT_IDLE**
  - Stay here while `din_s` = 0. This covers a line break or stuck-low line and prevents a false start.
  - When `din_s` = 1, go to IDLE.
- **State register:** the unused encodings 5–7 go to IDLE on the next clock.
- **Arithmetic:** counter and index compare only against the constants above. index never wraps past 7 because DATA exits at 7.

## Timing
- **Reset values:**
  - `data_rx` = 8'h00; `valid`, `frame_err`, `busy` = 0; `state` = IDLE.
  - Counter and index = 0; synchronizer flops = 1.
- **Reset mid-operation:** asserting `rst` during any frame aborts it immediately (asynchronous). No `valid` or `frame_err` is produced for the aborted frame.
- **Reference edge:** let E0 be the first clk edge that samples `din` = 0 at the start bit.
  - START is entered at E0+2.
  - Data bit i is sampled at E0+2+HALF+(i+1)·CLKS_PER_BIT.
  - The stop bit is sampled at E0+2+HALF+9·CLKS_PER_BIT; `valid` or `frame_err` is high for the one cycle following that edge.
  - At the default: bit 0 is sampled at E0+420 and `valid` rises at E0+2652.
- **Mutual exclusion:** `valid` and `frame_err` are never high in the same cycle.
- **Back-to-back frames:** the FSM returns to IDLE at the stop-bit midpoint. A start bit beginning immediately after a full-length stop bit is therefore caught without loss.
- **Glitch rejection:** a low pulse on `din_s` shorter than HALF clocks is rejected.

## Test plan
- **Reset:** assert `rst` mid-DATA with `din` = 0 → all outputs take their reset values at once; after release `state` = IDLE and no strobe appears.
- **Single byte:** transmitter loopback sends 8'hA5 at default parameter → exactly one `valid` pulse at E0+2652, `data_rx` = 8'hA5, `frame_err` stays 0.
- **Glitch:** hold `din` low 50 clocks, then high → START is entered then exited back to IDLE at E0+2+139; no `valid`, no `frame_err`, `data_rx` unchanged.
- **Framing error:** send 8'h3C with the stop bit driven 0 and the line held low 2000 clocks → one `frame_err` pulse, `data_rx` keeps its prior value, `state` = WAIT_IDLE until `din` rises, then IDLE.
- **Back-to-back:** transmitter sends 8'h00, 8'hFF, 8'h55 consecutively → three `valid` pulses spaced by the transmitter frame length, with `data_rx` = 8'h00, 8'hFF, 8'h55 in order.
- **Minimum parameter:** `CLKS_PER_BIT` = 4 with a matching stimulus sending 8'h81 → `valid` at E0+2+2+36 = E0+40, `data_rx` = 8'h81.
